// File: rtl/grant_arbiter.sv
// ---------------------------------------------------------------------------
// grant_arbiter
//
// Owns one shared resource and grants it to at most one of two requesters
// using a level REQ / registered GNT handshake. Fixed priority on ties from
// idle, no pre-emption of a current owner, and a hold timeout that revokes a
// grant held too long so that hold-and-wait deadlocks are broken. A revoked
// requester is locked out until it has dropped its request at least once.
//
// Parameters:
//   HOLD_MAX  max consecutive cycles a grant may stay high (0 = never revoke)
//   PRIO      requester (1 or 2) that wins a simultaneous request from idle
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RST      in   synchronous reset, active-high
//   REQ1     in   level request from requester 1
//   REQ2     in   level request from requester 2
//   GNT1     out  registered grant to requester 1
//   GNT2     out  registered grant to requester 2
//   REVOKED  out  one-cycle pulse per requester whose grant timed out
//                 (bit0 = requester 1, bit1 = requester 2)
//
// Optional feature macro: ROUND_ROBIN_EN
//   When defined, ties from idle alternate between the requesters using a
//   last-winner register and PRIO is ignored. Requester 1 wins the first tie
//   after reset.
// ---------------------------------------------------------------------------
module grant_arbiter #(
    parameter int HOLD_MAX = 17,
    parameter int PRIO     = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ1,
    input  logic       REQ2,
    output logic       GNT1,
    output logic       GNT2,
    output logic [1:0] REVOKED
);

    // A zero HOLD_MAX disables the timeout; keep a 1-bit counter so the
    // declarations stay legal even though the count is then never compared
    // against a reachable limit.
    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    // The counter is cleared on the edge that grants, so after the grant has
    // been visible for HOLD_MAX cycles it reads HOLD_MAX-1 at the next edge.
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN1 = 2'd1,
        ST_OWN2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             lock1_q, lock1_d;
    logic             lock2_q, lock2_d;
    logic [1:0]       revoked_q, revoked_d;
    logic             gnt1_q, gnt1_d;
    logic             gnt2_q, gnt2_d;

    logic             elig1, elig2;
    logic             timed_out;
    logic             tie_to_2;
    logic             grant1, grant2;

`ifdef ROUND_ROBIN_EN
    // 1 = requester 2 won the most recent grant.
    logic             last2_q, last2_d;
`endif

    // Next-state logic: eligibility, tie-break, grant/release/timeout
    // decisions, and the bookkeeping registers that follow from them.
    always_comb begin
        elig1     = REQ1 && !lock1_q;
        elig2     = REQ2 && !lock2_q;
        timed_out = (HOLD_MAX > 0) && (hold_cnt_q == HOLD_LAST);

`ifdef ROUND_ROBIN_EN
        tie_to_2  = !last2_q;
`else
        tie_to_2  = (PRIO == 2);
`endif

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        // Lockout is only released by sampling the request low.
        lock1_d    = lock1_q && REQ1;
        lock2_d    = lock2_q && REQ2;
        revoked_d  = 2'b00;
        grant1     = 1'b0;
        grant2     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (elig1 && elig2) begin
                    grant2 = tie_to_2;
                    grant1 = !tie_to_2;
                end else begin
                    grant1 = elig1;
                    grant2 = elig2;
                end
            end

            ST_OWN1: begin
                // A release takes precedence over a timeout on the same edge.
                if (!REQ1 || timed_out) begin
                    if (REQ1) begin
                        revoked_d[0] = 1'b1;
                        lock1_d      = 1'b1;
                    end
                    if (elig2) begin
                        grant2 = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end
                end
            end

            ST_OWN2: begin
                if (!REQ2 || timed_out) begin
                    if (REQ2) begin
                        revoked_d[1] = 1'b1;
                        lock2_d      = 1'b1;
                    end
                    if (elig1) begin
                        grant1 = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase

        // Every new grant, including a direct handoff, restarts the count.
        if (grant1) begin
            state_d    = ST_OWN1;
            hold_cnt_d = '0;
        end else if (grant2) begin
            state_d    = ST_OWN2;
            hold_cnt_d = '0;
        end

`ifdef ROUND_ROBIN_EN
        last2_d = last2_q;
        if (grant1) begin
            last2_d = 1'b0;
        end else if (grant2) begin
            last2_d = 1'b1;
        end
`endif

        gnt1_d = (state_d == ST_OWN1);
        gnt2_d = (state_d == ST_OWN2);
    end

    // All state and registered outputs. Reset discards any ownership without
    // producing a revocation pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            lock1_q    <= 1'b0;
            lock2_q    <= 1'b0;
            revoked_q  <= 2'b00;
            gnt1_q     <= 1'b0;
            gnt2_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            // Pretend requester 2 won last so requester 1 takes the first tie.
            last2_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            lock1_q    <= lock1_d;
            lock2_q    <= lock2_d;
            revoked_q  <= revoked_d;
            gnt1_q     <= gnt1_d;
            gnt2_q     <= gnt2_d;
`ifdef ROUND_ROBIN_EN
            last2_q    <= last2_d;
`endif
        end
    end

    assign GNT1    = gnt1_q;
    assign GNT2    = gnt2_q;
    assign REVOKED = revoked_q;

endmodule

// File: tb/tb_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grant_arbiter
//
// Directed bench for grant_arbiter. Three instances share clock, reset and
// request lines:
//   dut_a  HOLD_MAX=17, PRIO=1  tie / no pre-emption / handoff
//   dut_t  HOLD_MAX=4,  PRIO=1  timeout, lockout, release-vs-timeout
//   dut_p  HOLD_MAX=0,  PRIO=2  never-revoke and PRIO=2 tie-break
// Inputs change just after the falling edge; outputs are checked at the
// following falling edge, i.e. after exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_grant_arbiter;

    logic       clk;
    logic       rst;
    logic       req1;
    logic       req2;

    logic       gnt_a1, gnt_a2;
    logic [1:0] rev_a;
    logic       gnt_t1, gnt_t2;
    logic [1:0] rev_t;
    logic       gnt_p1, gnt_p2;
    logic [1:0] rev_p;

    int         compared;
    int         mismatched;
    bit         mutex_on;

    grant_arbiter #(.HOLD_MAX(17), .PRIO(1)) dut_a (
        .CLK(clk), .RST(rst), .REQ1(req1), .REQ2(req2),
        .GNT1(gnt_a1), .GNT2(gnt_a2), .REVOKED(rev_a)
    );

    grant_arbiter #(.HOLD_MAX(4), .PRIO(1)) dut_t (
        .CLK(clk), .RST(rst), .REQ1(req1), .REQ2(req2),
        .GNT1(gnt_t1), .GNT2(gnt_t2), .REVOKED(rev_t)
    );

    grant_arbiter #(.HOLD_MAX(0), .PRIO(2)) dut_p (
        .CLK(clk), .RST(rst), .REQ1(req1), .REQ2(req2),
        .GNT1(gnt_p1), .GNT2(gnt_p2), .REVOKED(rev_p)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [1:0] observed,
                               input logic [1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one set of inputs across exactly one rising edge and return at
    // the following falling edge, where outputs are stable.
    task automatic applyStimulus(input logic r, input logic a, input logic b);
        rst  = r;
        req1 = a;
        req2 = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Both grants high together is illegal for every instance.
    always @(negedge clk) begin
        if (mutex_on) begin
            checkOutput("mutex_a", {1'b0, gnt_a1 & gnt_a2}, 2'b00);
            checkOutput("mutex_t", {1'b0, gnt_t1 & gnt_t2}, 2'b00);
            checkOutput("mutex_p", {1'b0, gnt_p1 & gnt_p2}, 2'b00);
        end
    end

    initial begin
        logic [1:0] exp_a;
        logic [1:0] exp_p;

        compared   = 0;
        mismatched = 0;
        mutex_on   = 1'b0;
        rst        = 1'b1;
        req1       = 1'b0;
        req2       = 1'b0;
        @(negedge clk);

        // Reset held for two cycles with no requests.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            mutex_on = 1'b1;
            checkOutput("reset_gnt_a", {gnt_a2, gnt_a1}, 2'b00);
            checkOutput("reset_rev_a", rev_a, 2'b00);
            checkOutput("reset_gnt_t", {gnt_t2, gnt_t1}, 2'b00);
            checkOutput("reset_rev_t", rev_t, 2'b00);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_gnt_a", {gnt_a2, gnt_a1}, 2'b00);

        // Tie from idle, PRIO=1: requester 1 wins and is not pre-empted.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 5; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("tie_hold_a", {gnt_a2, gnt_a1}, 2'b01);
        end
        // Release with requester 2 waiting: direct handoff, no idle gap.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("handoff_a", {gnt_a2, gnt_a1}, 2'b10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("release_a", {gnt_a2, gnt_a1}, 2'b00);

        // Timeout with HOLD_MAX=4.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("to_e0_gnt", {gnt_t2, gnt_t1}, 2'b01);
        for (int e = 1; e < 4; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("to_hold_gnt", {gnt_t2, gnt_t1}, 2'b01);
            checkOutput("to_hold_rev", rev_t, 2'b00);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("to_e4_gnt", {gnt_t2, gnt_t1}, 2'b10);
        checkOutput("to_e4_rev", rev_t, 2'b01);
        checkOutput("norevoke_p_gnt", {gnt_p2, gnt_p1}, 2'b01);
        checkOutput("norevoke_p_rev", rev_p, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("to_e5_gnt", {gnt_t2, gnt_t1}, 2'b10);
        checkOutput("to_e5_rev", rev_t, 2'b00);

        // Lockout: requester 1 still high when requester 2 releases.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lock_e6_gnt", {gnt_t2, gnt_t1}, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lock_e7_gnt", {gnt_t2, gnt_t1}, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lock_clear_gnt", {gnt_t2, gnt_t1}, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lock_regrant", {gnt_t2, gnt_t1}, 2'b01);
        checkOutput("lock_regrant_rev", rev_t, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Release at exactly the timeout edge: release wins.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("coll_hold_gnt", {gnt_t2, gnt_t1}, 2'b01);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("coll_e4_gnt", {gnt_t2, gnt_t1}, 2'b00);
        checkOutput("coll_e4_rev", rev_t, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("coll_e5_rev", rev_t, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("coll_e6_gnt", {gnt_t2, gnt_t1}, 2'b01);

        // Reset mid-grant drops ownership without a revocation pulse.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rst_mid_gnt", {gnt_t2, gnt_t1}, 2'b00);
        checkOutput("rst_mid_rev", rev_t, 2'b00);

        // Repeated ties, both requesters releasing together each time.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
            exp_a = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_p = exp_a;
`else
            exp_a = 2'b01;
            exp_p = 2'b10;
`endif
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("ties_win_a", {gnt_a2, gnt_a1}, exp_a);
            checkOutput("ties_win_p", {gnt_p2, gnt_p1}, exp_p);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("ties_rel_a", {gnt_a2, gnt_a1}, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
